// File: rtl/task3_parameter.sv
// Shared parameters and types for the multiply-add operand loader.
package task3_parameter;

  // Operand width shared by the loader and the multiply-add stage
  localparam int size = 8;

  // Cycles from the multiply-add input sample to its data_out update
  localparam int MAC_LATENCY = 3;

  // Position of the next expected word inside an (A, B, C) triple
  typedef enum logic [1:0] {
    S_A,
    S_B,
    S_C
  } loader_state_t;

endpackage

// File: rtl/valid_delay_line.sv
// 1-bit shift register used to align a strobe with a fixed-latency pipeline.
module valid_delay_line #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] taps;

  // Shift the strobe one stage per clock; reset drops everything in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      taps <= '0;
    end else begin
      taps[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        taps[i] <= taps[i-1];
      end
    end
  end

  assign q = taps[DEPTH-1];

endmodule

// File: rtl/mac_operand_loader.sv
// Operand loader for the A*B+C multiply-add stage: assembles (A, B, C)
// triples from a valid-qualified word stream, issues them with a one-cycle
// strobe and flags the cycle in which the downstream result is ready.
// Optional build macro MAC_LOADER_COUNT_EN adds issue/resync counters.
module mac_operand_loader #(
  parameter int SIZE        = task3_parameter::size,
  parameter int MAC_LATENCY = task3_parameter::MAC_LATENCY
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [SIZE-1:0] in_data,
  input  logic            in_valid,
  input  logic            in_first,
  output logic [SIZE-1:0] A,
  output logic [SIZE-1:0] B,
  output logic [SIZE-1:0] C,
  output logic            issue,
  output logic            result_valid,
  output logic            resync_err
`ifdef MAC_LOADER_COUNT_EN
  ,
  output logic [15:0]     issue_count,
  output logic [7:0]      resync_count
`endif
);

  import task3_parameter::*;

  loader_state_t   state_q;
  loader_state_t   state_d;
  logic [SIZE-1:0] hold_a;
  logic [SIZE-1:0] hold_b;
  logic            load_a;
  logic            load_b;
  logic            clear_b;
  logic            load_triple;
  logic            resync;

  // Next-state and load decisions; nothing moves on cycles without in_valid
  always_comb begin
    state_d     = state_q;
    load_a      = 1'b0;
    load_b      = 1'b0;
    clear_b     = 1'b0;
    load_triple = 1'b0;
    resync      = 1'b0;
    if (in_valid) begin
      case (state_q)
        S_A: begin
          load_a  = 1'b1;
          state_d = S_B;
        end
        S_B: begin
          if (in_first) begin
            load_a = 1'b1;
            resync = 1'b1;
          end else begin
            load_b  = 1'b1;
            state_d = S_C;
          end
        end
        S_C: begin
          if (in_first) begin
            load_a  = 1'b1;
            clear_b = 1'b1;
            resync  = 1'b1;
            state_d = S_B;
          end else begin
            load_triple = 1'b1;
            state_d     = S_A;
          end
        end
        default: begin
          state_d = S_A;
        end
      endcase
    end
  end

  // State, holding registers, issued triple and the single-cycle strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_A;
      hold_a     <= '0;
      hold_b     <= '0;
      A          <= '0;
      B          <= '0;
      C          <= '0;
      issue      <= 1'b0;
      resync_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_a) begin
        hold_a <= in_data;
      end
      if (load_b) begin
        hold_b <= in_data;
      end else if (clear_b) begin
        hold_b <= '0;
      end
      if (load_triple) begin
        A <= hold_a;
        B <= hold_b;
        C <= in_data;
      end
      issue      <= load_triple;
      resync_err <= resync;
    end
  end

  valid_delay_line #(
    .DEPTH(MAC_LATENCY)
  ) u_result_delay (
    .clk  (clk),
    .reset(reset),
    .d    (issue),
    .q    (result_valid)
  );

`ifdef MAC_LOADER_COUNT_EN
  // Issue counter wraps; resync counter sticks at its maximum
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_count  <= 16'd0;
      resync_count <= 8'd0;
    end else begin
      if (issue) begin
        issue_count <= issue_count + 16'd1;
      end
      if (resync_err && (resync_count != 8'hFF)) begin
        resync_count <= resync_count + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mac_operand_loader.sv
// Self-checking bench for mac_operand_loader: a per-cycle vector table
// plus hand-written reset and counter sequences.
module tb_mac_operand_loader;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_first;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] c;
  logic       issue;
  logic       result_valid;
  logic       resync_err;
`ifdef MAC_LOADER_COUNT_EN
  logic [15:0] issue_count;
  logic [7:0]  resync_count;
`endif

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic       v;
    logic       f;
    logic [7:0] d;
    logic       e_issue;
    logic       e_rerr;
    logic       e_rv;
    logic [7:0] ea;
    logic [7:0] eb;
    logic [7:0] ec;
    int         e_mac;
  } vec_t;

  vec_t vecs[$];
  int   mac_q[$];

  mac_operand_loader dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_first    (in_first),
    .A           (a),
    .B           (b),
    .C           (c),
    .issue       (issue),
    .result_valid(result_valid),
    .resync_err  (resync_err)
`ifdef MAC_LOADER_COUNT_EN
    ,
    .issue_count (issue_count),
    .resync_count(resync_count)
`endif
  );

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic v, input logic f, input logic [7:0] d);
    in_valid = v;
    in_first = f;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic addRow(input logic v, input logic f, input int d,
                        input logic iss, input logic rerr, input logic rv,
                        input int ea, input int eb, input int ec, input int mac);
    vec_t r;
    r.v = v; r.f = f; r.d = d[7:0];
    r.e_issue = iss; r.e_rerr = rerr; r.e_rv = rv;
    r.ea = ea[7:0]; r.eb = eb[7:0]; r.ec = ec[7:0];
    r.e_mac = mac;
    vecs.push_back(r);
  endtask

  // Downstream multiply-add reference: result of each issued triple, in order
  task automatic trackMac(input string name, input logic exp_rv, input int exp_mac);
    int got;
    if (result_valid) begin
      if (mac_q.size() == 0) begin
        checkOutput({name, " unexpected result_valid"}, 1, 0);
      end else begin
        got = mac_q.pop_front();
        if (exp_rv) checkOutput({name, " data_out"}, got, exp_mac);
      end
    end
    if (issue) mac_q.push_back(int'(a) * int'(b) + int'(c));
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_data  = 8'd0;

    //      v  f  d    iss rerr rv  A    B    C    mac
    addRow(1, 1, 3,   0, 0, 0,   0,   0,   0,   0);
    addRow(1, 0, 5,   0, 0, 0,   0,   0,   0,   0);
    addRow(1, 0, 7,   1, 0, 0,   3,   5,   7,   0);
    addRow(0, 0, 0,   0, 0, 0,   3,   5,   7,   0);
    addRow(0, 1, 0,   0, 0, 0,   3,   5,   7,   0);
    addRow(0, 0, 0,   0, 0, 1,   3,   5,   7,   22);
    addRow(0, 0, 0,   0, 0, 0,   3,   5,   7,   0);
    addRow(1, 1, 255, 0, 0, 0,   3,   5,   7,   0);
    addRow(1, 0, 255, 0, 0, 0,   3,   5,   7,   0);
    addRow(1, 0, 255, 1, 0, 0,   255, 255, 255, 0);
    addRow(1, 1, 1,   0, 0, 0,   255, 255, 255, 0);
    addRow(1, 0, 2,   0, 0, 0,   255, 255, 255, 0);
    addRow(1, 0, 3,   1, 0, 1,   1,   2,   3,   65280);
    addRow(0, 0, 0,   0, 0, 0,   1,   2,   3,   0);
    addRow(0, 0, 0,   0, 0, 0,   1,   2,   3,   0);
    addRow(0, 0, 0,   0, 0, 1,   1,   2,   3,   5);
    addRow(0, 0, 0,   0, 0, 0,   1,   2,   3,   0);
    addRow(1, 1, 4,   0, 0, 0,   1,   2,   3,   0);
    addRow(0, 1, 0,   0, 0, 0,   1,   2,   3,   0);
    addRow(0, 0, 0,   0, 0, 0,   1,   2,   3,   0);
    addRow(1, 0, 6,   0, 0, 0,   1,   2,   3,   0);
    addRow(0, 0, 0,   0, 0, 0,   1,   2,   3,   0);
    addRow(0, 0, 0,   0, 0, 0,   1,   2,   3,   0);
    addRow(1, 0, 9,   1, 0, 0,   4,   6,   9,   0);
    addRow(0, 0, 0,   0, 0, 0,   4,   6,   9,   0);
    addRow(0, 0, 0,   0, 0, 0,   4,   6,   9,   0);
    addRow(0, 0, 0,   0, 0, 1,   4,   6,   9,   33);
    addRow(0, 0, 0,   0, 0, 0,   4,   6,   9,   0);
    addRow(1, 1, 10,  0, 0, 0,   4,   6,   9,   0);
    addRow(1, 0, 20,  0, 0, 0,   4,   6,   9,   0);
    addRow(1, 1, 30,  0, 1, 0,   4,   6,   9,   0);
    addRow(1, 0, 40,  0, 0, 0,   4,   6,   9,   0);
    addRow(1, 0, 50,  1, 0, 0,   30,  40,  50,  0);
    addRow(0, 0, 0,   0, 0, 0,   30,  40,  50,  0);
    addRow(0, 0, 0,   0, 0, 0,   30,  40,  50,  0);
    addRow(0, 0, 0,   0, 0, 1,   30,  40,  50,  1250);
    addRow(1, 1, 11,  0, 0, 0,   30,  40,  50,  0);
    addRow(1, 1, 12,  0, 1, 0,   30,  40,  50,  0);
    addRow(1, 0, 13,  0, 0, 0,   30,  40,  50,  0);
    addRow(1, 0, 14,  1, 0, 0,   12,  13,  14,  0);
    addRow(0, 0, 0,   0, 0, 0,   12,  13,  14,  0);
    addRow(0, 0, 0,   0, 0, 0,   12,  13,  14,  0);
    addRow(0, 0, 0,   0, 0, 1,   12,  13,  14,  170);
    addRow(1, 0, 100, 0, 0, 0,   12,  13,  14,  0);
    addRow(1, 0, 1,   0, 0, 0,   12,  13,  14,  0);
    addRow(1, 0, 2,   1, 0, 0,   100, 1,   2,   0);
    addRow(0, 0, 0,   0, 0, 0,   100, 1,   2,   0);
    addRow(0, 0, 0,   0, 0, 0,   100, 1,   2,   0);
    addRow(0, 0, 0,   0, 0, 1,   100, 1,   2,   102);

    // Reset state while reset is held
    #12;
    checkOutput("reset A", a, 0);
    checkOutput("reset B", b, 0);
    checkOutput("reset C", c, 0);
    checkOutput("reset issue", issue, 0);
    checkOutput("reset result_valid", result_valid, 0);
    checkOutput("reset resync_err", resync_err, 0);
`ifdef MAC_LOADER_COUNT_EN
    checkOutput("reset issue_count", issue_count, 0);
    checkOutput("reset resync_count", resync_count, 0);
`endif
    @(negedge clk);
    reset = 1'b0;

    // Table-driven per-cycle vectors
    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("row%0d", i);
      applyStimulus(vecs[i].v, vecs[i].f, vecs[i].d);
      checkOutput({tag, " issue"}, issue, vecs[i].e_issue);
      checkOutput({tag, " resync_err"}, resync_err, vecs[i].e_rerr);
      checkOutput({tag, " result_valid"}, result_valid, vecs[i].e_rv);
      checkOutput({tag, " A"}, a, vecs[i].ea);
      checkOutput({tag, " B"}, b, vecs[i].eb);
      checkOutput({tag, " C"}, c, vecs[i].ec);
      trackMac(tag, vecs[i].e_rv, vecs[i].e_mac);
    end

`ifdef MAC_LOADER_COUNT_EN
    checkOutput("table issue_count", issue_count, 7);
    checkOutput("table resync_count", resync_count, 2);
`endif

    // Reset one cycle after an issue, with a partial triple pending
    applyStimulus(1, 1, 2);
    applyStimulus(1, 0, 3);
    applyStimulus(1, 0, 4);
    checkOutput("midreset issue", issue, 1);
    checkOutput("midreset A", a, 2);
    checkOutput("midreset C", c, 4);
    applyStimulus(1, 1, 50);
    reset = 1'b1;
    #1;
    checkOutput("async reset A", a, 0);
    checkOutput("async reset B", b, 0);
    checkOutput("async reset C", c, 0);
    checkOutput("async reset issue", issue, 0);
    checkOutput("async reset result_valid", result_valid, 0);
    checkOutput("async reset resync_err", resync_err, 0);
    mac_q.delete();
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0);
      checkOutput($sformatf("post-reset idle%0d result_valid", i), result_valid, 0);
    end
    applyStimulus(1, 0, 7);
    checkOutput("restart w0 resync_err", resync_err, 0);
    applyStimulus(1, 0, 8);
    checkOutput("restart w1 issue", issue, 0);
    applyStimulus(1, 0, 9);
    checkOutput("restart issue", issue, 1);
    checkOutput("restart A", a, 7);
    checkOutput("restart B", b, 8);
    checkOutput("restart C", c, 9);
    trackMac("restart", 1'b0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("restart idle issue", issue, 0);
    applyStimulus(0, 0, 0);
    checkOutput("restart early result_valid", result_valid, 0);
    applyStimulus(0, 0, 0);
    checkOutput("restart result_valid", result_valid, 1);
    trackMac("restart", 1'b1, 65);

`ifdef MAC_LOADER_COUNT_EN
    checkOutput("restart issue_count", issue_count, 1);
    checkOutput("restart resync_count", resync_count, 0);
    // One word to reach S_B, then 300 resyncs in a row
    for (int i = 0; i < 301; i++) begin
      applyStimulus(1, 1, i[7:0]);
    end
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("saturated resync_count", resync_count, 255);
    checkOutput("resync issue_count", issue_count, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mac_operand_loader.md
Name: mac_operand_loader

Overview:
Upstream feeder for the pipelined multiply-add stage that computes data_out = A*B + C with 3-cycle latency.
- Accepts a single-word valid-qualified operand stream and assembles ordered triples (A, B, C).
- Presents each completed triple to the multiply-add stage together with a one-cycle issue strobe.
- Tracks in-flight triples so that result_valid aligns exactly with the multiply-add data_out.

Parameters:
SIZE, 8 (taken from task3_parameter::size), operand width.
MAC_LATENCY, 3, cycles from the multiply-add input sample to its data_out update.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_data  input  SIZE  operand word
in_valid  input  1  in_data valid this cycle; the block is always ready, so every valid cycle is a transfer
in_first  input  1  marks the word as operand A (frame resync); qualified by in_valid
A  output  SIZE  operand A to the multiply-add stage
B  output  SIZE  operand B to the multiply-add stage
C  output  SIZE  operand C to the multiply-add stage
issue  output  1  one-cycle pulse: A/B/C hold a new triple
result_valid  output  1  high in the cycle in which the multiply-add data_out holds the result of an issued triple
resync_err  output  1  one-cycle pulse: a partial triple was discarded

Behaviour:
- Reset: asynchronous and active-high; clears everything immediately.
  - A, B, C = 0; issue = 0; result_valid = 0; resync_err = 0.
  - FSM returns to S_A; all internal holding registers are cleared.
  - The delay line is cleared, so in-flight results are dropped and never flagged valid.
- FSM states: S_A, S_B, S_C. Transitions happen only on cycles with in_valid = 1.
  - S_A: capture in_data into hold_a; go to S_B. This applies regardless of in_first.
  - S_B with in_first = 0: capture hold_b; go to S_C.
  - S_B with in_first = 1: discard hold_a; capture in_data as the new hold_a; stay in S_B; pulse resync_err.
  - S_C with in_first = 0:
    - Register A <= hold_a, B <= hold_b, C <= in_data.
    - issue = 1 for the following cycle only.
    - Go to S_A.
  - S_C with in_first = 1: discard hold_a and hold_b; capture in_data as hold_a; go to S_B; pulse resync_err.
- in_valid = 0: no state change and no outputs change. issue and resync_err drop to 0 after one cycle.
- Output hold: A, B, C keep the last issued triple until the next issue. They never show partial data.
- Latency:
  - The C word accepted at edge k makes issue = 1 in the cycle after edge k.
  - The multiply-add stage samples the triple at edge k+1.
  - result_valid = issue delayed by MAC_LATENCY registers, so it is high in the cycle after edge k+MAC_LATENCY.
- Throughput: at most one triple per 3 valid words. Back-to-back triples give issue pulses 3 cycles apart, and the delay line handles overlapping in-flight results.
- Width: no arithmetic in this block. The downstream 2*SIZE result covers the maximum (2^SIZE-1)^2 + (2^SIZE-1).

Optional Feature:
Macro MAC_LOADER_COUNT_EN.
- Defined:
  - Adds output issue_count [15:0], reset 0.
  - Increments on each issue pulse and wraps 0xFFFF -> 0x0000.
  - Adds output resync_count [7:0], which saturates at 0xFF.
- Undefined: neither port nor its logic exists.

Decomposition:
- Package task3_parameter gains:
  - typedef enum logic [1:0] loader_state_t {S_A, S_B, S_C};
  - localparam MAC_LATENCY = 3.
  - size remains the shared operand width.
- One sub-module: valid_delay_line (parameter DEPTH). It is a 1-bit shift register with asynchronous reset and is instantiated with DEPTH = MAC_LATENCY for result_valid.

Test Plan:
- Basic triple: SIZE=8, words 3, 5, 7 on consecutive cycles, in_first=1 on the 3.
  - A=3, B=5, C=7 with a single issue pulse.
  - result_valid high exactly 3 cycles after issue, when the downstream data_out = 22.
- Back-to-back triples: (255,255,255) then (1,2,3) with no gaps.
  - Two issue pulses 3 cycles apart.
  - result_valid pulses align with data_out 65280 and then 5.
- Idle gaps: words 4, 6, 9 separated by 2 idle cycles each.
  - No state advance while idle; single issue after the 9; output 33 flagged.
- Resync: 10, 20, then 30 with in_first=1, then 40, 50.
  - resync_err pulses once.
  - Issued triple is (30, 40, 50); no issue for the 10/20 fragment.
- Reset mid-flight: assert reset one cycle after issue of (2,3,4).
  - All outputs 0 immediately; result_valid never rises for that triple.
  - After release, the next triple starts in S_A.
- With MAC_LOADER_COUNT_EN defined: 65537 triples give issue_count = 1; 300 resyncs give resync_count = 0xFF.
